mem_arbiter: RTL and testbench

//  Shares the single 16-bit main memory between the I-cache fill, D-cache fill and D-cache

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_beat_counter.sv | 26 ++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned BLK_WORDS = 8;
    localparam int unsigned BEAT_W    = $clog2(BLK_WORDS);

    // Block is BLK_WORDS 16-bit words = 16 bytes, so the low 4 address bits select within it.
    localparam logic [ADDR_W-1:0] BLK_MASK = 16'hFFF0;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StWrite = 2'b01,
        StFillI = 2'b10,
        StFillD = 2'b11
    } arb_state_e;

    typedef enum logic {
        GrantI = 1'b0,
        GrantD = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arbiter_beat_counter.sv
// Beat counter for block transfers: up counter with sync clear, wrap flag on the last beat.
module mem_arbiter_beat_counter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [BEAT_W-1:0] count,
    output logic              wrap
);

    logic [BEAT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
    assign wrap  = (count_q == BEAT_W'(BLK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: grants the I-fill, D-fill or D-store path one at a time and sequences
// pipelined 8-beat block reads or single-cycle word writes.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [ADDR_W-1:0] d_wr_data,
    input  logic [ADDR_W-1:0] mem_data_out,
    input  logic              mem_data_vld,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_data_in,
    output logic              i_busy,
    output logic              d_busy,
    output logic              i_data_wen,
    output logic              d_data_wen,
    output logic [BEAT_W-1:0] fill_beat,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_done
);

    arb_state_e        state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              iss_done_q;
    logic              grant_i, grant_d;
    logic              filling, issuing, ret_vld;
    logic [BEAT_W-1:0] iss_cnt, ret_cnt;
    logic              iss_wrap, ret_wrap;
    logic              unused_data;

    assign filling = (state_q == StFillI) || (state_q == StFillD);
    assign issuing = filling && !iss_done_q;
    assign ret_vld = filling && mem_data_vld;

    // Read data goes straight from memory to the cache data arrays.
    assign unused_data = ^mem_data_out;

    mem_arbiter_beat_counter u_iss_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (!filling),
        .inc   (issuing),
        .count (iss_cnt),
        .wrap  (iss_wrap)
    );

    mem_arbiter_beat_counter u_ret_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (!filling),
        .inc   (ret_vld),
        .count (ret_cnt),
        .wrap  (ret_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= GrantD;
            base_q       <= '0;
            iss_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            base_q       <= base_d;
            iss_done_q   <= filling && (iss_done_q || (issuing && iss_wrap));
        end
    end

    // Stores win outright; a miss tie goes to the cache not served last. Stores do not
    // touch last_grant so the miss alternation is unaffected by write traffic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        base_d       = base_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (d_wr_req) begin
                    state_d = StWrite;
                end else if (i_miss && (!d_miss || last_grant_q == GrantD)) begin
                    grant_i      = 1'b1;
                    state_d      = StFillI;
                    base_d       = i_miss_addr & BLK_MASK;
                    last_grant_d = GrantI;
                end else if (d_miss) begin
                    grant_d      = 1'b1;
                    state_d      = StFillD;
                    base_d       = d_miss_addr & BLK_MASK;
                    last_grant_d = GrantD;
                end
            end
            StWrite: state_d = StIdle;
            StFillI, StFillD: begin
                if (ret_vld && ret_wrap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are forced low while rst is high so no beat or done escapes during reset.
    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        i_busy      = 1'b0;
        d_busy      = 1'b0;
        i_data_wen  = 1'b0;
        d_data_wen  = 1'b0;
        fill_beat   = '0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_done   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    i_busy = grant_i;
                    d_busy = grant_d;
                end
                StWrite: begin
                    mem_en      = 1'b1;
                    mem_wr      = 1'b1;
                    mem_addr    = d_wr_addr;
                    mem_data_in = d_wr_data;
                    d_wr_done   = 1'b1;
                end
                StFillI, StFillD: begin
                    mem_en = issuing;
                    if (issuing) begin
                        mem_addr = base_q | ADDR_W'({iss_cnt, 1'b0});
                    end
                    fill_beat   = ret_cnt;
                    i_busy      = (state_q == StFillI);
                    d_busy      = (state_q == StFillD);
                    i_data_wen  = (state_q == StFillI) && mem_data_vld;
                    d_data_wen  = (state_q == StFillD) && mem_data_vld;
                    i_fill_done = i_data_wen && ret_wrap;
                    d_fill_done = d_data_wen && ret_wrap;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model and a fixed-latency memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
    logic [15:0] mem_data_out = '0;
    logic        mem_data_vld = 1'b0;
    logic        mem_en, mem_wr, i_busy, d_busy, i_data_wen, d_data_wen;
    logic        i_fill_done, d_fill_done, d_wr_done;
    logic [15:0] mem_addr, mem_data_in;
    logic [2:0]  fill_beat;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_miss       (i_miss),
        .i_miss_addr  (i_miss_addr),
        .d_miss       (d_miss),
        .d_miss_addr  (d_miss_addr),
        .d_wr_req     (d_wr_req),
        .d_wr_addr    (d_wr_addr),
        .d_wr_data    (d_wr_data),
        .mem_data_out (mem_data_out),
        .mem_data_vld (mem_data_vld),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .i_busy       (i_busy),
        .d_busy       (d_busy),
        .i_data_wen   (i_data_wen),
        .d_data_wen   (d_data_wen),
        .fill_beat    (fill_beat),
        .i_fill_done  (i_fill_done),
        .d_fill_done  (d_fill_done),
        .d_wr_done    (d_wr_done)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Inputs for the next cycle; applied at the following negedge.
    logic        nx_rst = 1'b1, nx_i_miss = 1'b0, nx_d_miss = 1'b0, nx_d_wr = 1'b0;
    logic [15:0] nx_i_addr = '0, nx_d_addr = '0, nx_wr_addr = '0, nx_wr_data = '0;

    // Memory: each read returns exactly 4 cycles after issue unless stalled by a gap.
    typedef struct {
        int          ready;
        logic [15:0] data;
    } ret_t;
    ret_t mq[$];
    int   gap_left = 0;
    bit   rand_gaps = 1'b0;

    // Model: service kind (0 none, 1 write, 2 I fill, 3 D fill), cycle within fill, returns.
    int          m_srv = 0;
    int          m_k = 0;
    int          m_rets = 0;
    logic [15:0] m_base = '0;
    bit          m_last_d = 1'b1;

    // Observation logs for the directed scenarios.
    logic [15:0] addr_log[$];
    logic [15:0] din_log[$];
    logic        wr_log[$];
    int          beat_log[$];
    int          done_order[$];
    int          idone_cyc, ddone_cyc, igrant_cyc, dgrant_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] memval(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic clear_logs();
        addr_log.delete();
        din_log.delete();
        wr_log.delete();
        beat_log.delete();
        done_order.delete();
        idone_cyc = -1;
        ddone_cyc = -1;
        igrant_cyc = -1;
        dgrant_cyc = -1;
    endtask

    task automatic step();
        ret_t        r;
        int          win;
        logic        e_en, e_wr, e_ib, e_db, e_iw, e_dw, e_idone, e_ddone, e_wdone;
        logic [15:0] e_addr, e_din;
        int          e_beat;
        @(negedge clk);
        rst         = nx_rst;
        i_miss      = nx_i_miss;
        i_miss_addr = nx_i_addr;
        d_miss      = nx_d_miss;
        d_miss_addr = nx_d_addr;
        d_wr_req    = nx_d_wr;
        d_wr_addr   = nx_wr_addr;
        d_wr_data   = nx_wr_data;
        if (gap_left > 0) begin
            gap_left--;
            mem_data_vld = 1'b0;
        end else if (mq.size() > 0 && mq[0].ready <= cyc &&
                     !(rand_gaps && $urandom_range(0, 5) == 0)) begin
            r = mq.pop_front();
            mem_data_vld = 1'b1;
            mem_data_out = r.data;
        end else begin
            mem_data_vld = 1'b0;
            mem_data_out = 16'($urandom);
        end
        #1;
        win = 0;
        {e_en, e_wr, e_ib, e_db, e_iw, e_dw, e_idone, e_ddone, e_wdone} = '0;
        e_addr = '0;
        e_din  = '0;
        e_beat = 0;
        if (!rst) begin
            if (m_srv == 0) begin
                if (!d_wr_req) begin
                    if (i_miss && (!d_miss || m_last_d)) win = 1;
                    else if (d_miss) win = 2;
                end
                e_ib = (win == 1);
                e_db = (win == 2);
            end else if (m_srv == 1) begin
                e_en    = 1'b1;
                e_wr    = 1'b1;
                e_addr  = d_wr_addr;
                e_din   = d_wr_data;
                e_wdone = 1'b1;
            end else begin
                e_ib = (m_srv == 2);
                e_db = (m_srv == 3);
                if (m_k >= 1 && m_k <= 8) begin
                    e_en   = 1'b1;
                    e_addr = m_base + 16'(2 * (m_k - 1));
                end
                e_beat = m_rets;
                e_iw   = e_ib && mem_data_vld;
                e_dw   = e_db && mem_data_vld;
                e_idone = e_iw && (m_rets == 7);
                e_ddone = e_dw && (m_rets == 7);
            end
        end
        chk("mem_en", 32'(mem_en), 32'(e_en));
        if (e_en) begin
            chk("mem_wr", 32'(mem_wr), 32'(e_wr));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_wr) chk("mem_data_in", 32'(mem_data_in), 32'(e_din));
        end
        chk("i_busy", 32'(i_busy), 32'(e_ib));
        chk("d_busy", 32'(d_busy), 32'(e_db));
        chk("i_data_wen", 32'(i_data_wen), 32'(e_iw));
        chk("d_data_wen", 32'(d_data_wen), 32'(e_dw));
        chk("fill_beat", 32'(fill_beat), 32'(e_beat));
        chk("i_fill_done", 32'(i_fill_done), 32'(e_idone));
        chk("d_fill_done", 32'(d_fill_done), 32'(e_ddone));
        chk("d_wr_done", 32'(d_wr_done), 32'(e_wdone));

        if (mem_en) begin
            addr_log.push_back(mem_addr);
            wr_log.push_back(mem_wr);
            din_log.push_back(mem_data_in);
            if (!mem_wr) mq.push_back('{cyc + 4, memval(mem_addr)});
        end
        if (i_data_wen || d_data_wen) beat_log.push_back(int'(fill_beat));
        if (i_fill_done) begin idone_cyc = cyc; done_order.push_back(1); end
        if (d_fill_done) begin ddone_cyc = cyc; done_order.push_back(2); end
        if (i_busy && igrant_cyc < 0) igrant_cyc = cyc;
        if (d_busy && dgrant_cyc < 0) dgrant_cyc = cyc;

        if (rst) begin
            m_srv = 0; m_k = 0; m_rets = 0; m_last_d = 1'b1;
        end else if (m_srv == 0) begin
            if (d_wr_req) begin
                m_srv = 1;
            end else if (win != 0) begin
                m_srv    = win + 1;
                m_base   = ((win == 1) ? i_miss_addr : d_miss_addr) & 16'hFFF0;
                m_last_d = (win == 2);
                m_k      = 1;
                m_rets   = 0;
            end
        end else if (m_srv == 1) begin
            m_srv = 0;
        end else begin
            m_k++;
            if (mem_data_vld) begin
                if (m_rets == 7) begin m_srv = 0; m_rets = 0; end
                else m_rets++;
            end
        end
        // Requesters drop their request once they see completion.
        if (e_idone) nx_i_miss = 1'b0;
        if (e_ddone) nx_d_miss = 1'b0;
        if (e_wdone) nx_d_wr = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        nx_rst = 1'b1; nx_i_miss = 1'b0; nx_d_miss = 1'b0; nx_d_wr = 1'b0;
        step();
        step();
        nx_rst = 1'b0;
        step();
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        for (int i = 0; i < budget && done_order.size() < n; i++) step();
        chk(name, 32'(done_order.size()), 32'(n));
    endtask

    initial begin
        bit gapped;
        clear_logs();
        do_reset();
        chk("reset_quiet", {mem_en, i_busy, d_busy, i_data_wen, d_data_wen, d_wr_done}, '0);

        // 1: single I fill, addresses, beats, latency
        clear_logs();
        nx_i_miss = 1'b1; nx_i_addr = 16'h1236;
        wait_done(1, 40, "t1_done");
        chk("t1_nreads", 32'(addr_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < addr_log.size()) chk("t1_addr", 32'(addr_log[i]), 32'(16'h1230 + 2 * i));
            if (i < beat_log.size()) chk("t1_beat", 32'(beat_log[i]), 32'(i));
        end
        chk("t1_nbeats", 32'(beat_log.size()), 32'd8);
        chk("t1_latency", 32'(idone_cyc - igrant_cyc), 32'd12);

        // 2: store beats a simultaneous D miss, then D fill
        do_reset();
        clear_logs();
        nx_d_wr = 1'b1; nx_wr_addr = 16'h0040; nx_wr_data = 16'hBEEF;
        nx_d_miss = 1'b1; nx_d_addr = 16'h0040;
        wait_done(1, 40, "t2_done");
        chk("t2_nmem", 32'(addr_log.size()), 32'd9);
        if (addr_log.size() >= 2) begin
            chk("t2_first_wr", 32'(wr_log[0]), 32'd1);
            chk("t2_wr_addr", 32'(addr_log[0]), 32'h0040);
            chk("t2_wr_data", 32'(din_log[0]), 32'hBEEF);
            chk("t2_fill_rd", 32'(wr_log[1]), 32'd0);
            chk("t2_fill_base", 32'(addr_log[1]), 32'h0040);
        end
        if (done_order.size() > 0) chk("t2_who", 32'(done_order[0]), 32'd2);

        // 3: both misses held; alternation I, D, I
        do_reset();
        clear_logs();
        nx_i_miss = 1'b1; nx_i_addr = 16'h2004;
        nx_d_miss = 1'b1; nx_d_addr = 16'h300A;
        for (int i = 0; i < 120 && done_order.size() < 3; i++) begin
            step();
            if (!nx_i_miss && done_order.size() < 2) nx_i_miss = 1'b1;
            if (!nx_d_miss && done_order.size() < 2) nx_d_miss = 1'b1;
        end
        chk("t3_ndone", 32'(done_order.size()), 32'd3);
        if (done_order.size() >= 3) begin
            chk("t3_first", 32'(done_order[0]), 32'd1);
            chk("t3_second", 32'(done_order[1]), 32'd2);
            chk("t3_third", 32'(done_order[2]), 32'd1);
        end
        if (addr_log.size() > 8) chk("t3_d_base", 32'(addr_log[8]), 32'h3000);

        // 4: valid withheld 2 cycles after the 4th return
        do_reset();
        clear_logs();
        gapped = 1'b0;
        nx_i_miss = 1'b1; nx_i_addr = 16'h4458;
        for (int i = 0; i < 40 && done_order.size() < 1; i++) begin
            step();
            if (beat_log.size() == 4 && !gapped) begin gap_left = 2; gapped = 1'b1; end
        end
        chk("t4_done", 32'(done_order.size()), 32'd1);
        chk("t4_latency", 32'(idone_cyc - igrant_cyc), 32'd14);
        chk("t4_nbeats", 32'(beat_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < beat_log.size()) chk("t4_beat", 32'(beat_log[i]), 32'(i));
        if (addr_log.size() > 0) chk("t4_base", 32'(addr_log[0]), 32'h4450);

        // 5: reset after 5 returns of a D fill
        do_reset();
        clear_logs();
        nx_d_miss = 1'b1; nx_d_addr = 16'h5000;
        for (int i = 0; i < 30 && beat_log.size() < 5; i++) step();
        chk("t5_five", 32'(beat_log.size()), 32'd5);
        nx_rst = 1'b1; nx_d_miss = 1'b0;
        step();
        nx_rst = 1'b0;
        clear_logs();
        step();
        chk("t5_idle", {mem_en, i_busy, d_busy, d_data_wen, d_fill_done, 13'(fill_beat)}, '0);
        repeat (6) step();
        chk("t5_no_wen", 32'(beat_log.size()), 32'd0);
        chk("t5_no_done", 32'(done_order.size()), 32'd0);
        chk("t5_drained", 32'(mq.size()), 32'd0);

        // 6: D miss raised during an I fill waits for the next IDLE
        do_reset();
        clear_logs();
        nx_i_miss = 1'b1; nx_i_addr = 16'h6000;
        repeat (3) step();
        nx_d_miss = 1'b1; nx_d_addr = 16'h7010;
        wait_done(2, 60, "t6_both");
        chk("t6_order", 32'(done_order.size() > 0 ? done_order[0] : 0), 32'd1);
        chk("t6_d_grant", 32'(dgrant_cyc - idone_cyc), 32'd1);

        // Random traffic with random gaps and occasional resets
        do_reset();
        rand_gaps = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            nx_rst = ($urandom_range(0, 299) == 0);
            if (!nx_i_miss && $urandom_range(0, 3) == 0) begin
                nx_i_miss = 1'b1; nx_i_addr = 16'($urandom);
            end
            if (!nx_d_miss && $urandom_range(0, 3) == 0) begin
                nx_d_miss = 1'b1; nx_d_addr = 16'($urandom);
            end
            if (!nx_d_wr && $urandom_range(0, 7) == 0) begin
                nx_d_wr = 1'b1; nx_wr_addr = 16'($urandom); nx_wr_data = 16'($urandom);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
